// File: rtl/shared_mem_responder.sv
// shared_mem_responder: round-robin arbiter granting one core per cycle into a byte-writable RAM,
// answering every accepted request with a one-cycle response pulse on the granted core.
module shared_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int NCORES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NCORES-1:0]        req_valid,
  input  logic [NCORES-1:0]        req_we,
  input  logic [32*NCORES-1:0]     req_addr,
  input  logic [32*NCORES-1:0]     req_wdata,
  input  logic [4*NCORES-1:0]      req_be,
  output logic [NCORES-1:0]        req_ready,
  output logic [NCORES-1:0]        rsp_valid,
  output logic [32*NCORES-1:0]     rsp_rdata
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(NCORES);
  logic [31:0] mem [DEPTH_WORDS];
  logic [PW-1:0] ptr, gidx, cand;
  logic [NCORES-1:0] gnt;
  logic accept, sel_we, unused_addr_bits;
  logic [31:0] sel_addr, sel_wdata;
  logic [3:0] sel_be;
  logic [AW-1:0] widx;
  // Scan from lowest priority to highest so the core at ptr overrides everyone else.
  always_comb begin
    gnt = '0;
    gidx = '0;
    cand = '0;
    for (int k = NCORES - 1; k >= 0; k--) begin
      cand = ptr + PW'(k);
      if (req_valid[cand]) begin
        gnt = '0;
        gnt[cand] = 1'b1;
        gidx = cand;
      end
    end
  end
  assign req_ready = rst_n ? gnt : '0;
  assign accept = |req_ready;
  assign sel_we = req_we[gidx];
  assign sel_addr = req_addr[32*gidx +: 32];
  assign sel_wdata = req_wdata[32*gidx +: 32];
  assign sel_be = req_be[4*gidx +: 4];
  assign widx = sel_addr[AW+1:2];
  assign unused_addr_bits = ^{sel_addr[31:AW+2], sel_addr[1:0]};
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (accept && sel_we && sel_be[b]) mem[widx][8*b +: 8] <= sel_wdata[8*b +: 8];
  end
  // Write responses leave the data lane untouched; only reads refresh it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= req_ready;
      if (accept) ptr <= gidx + 1'b1;
      if (accept && !sel_we) rsp_rdata[32*gidx +: 32] <= mem[widx];
    end
  end
endmodule

// File: tb/tb_shared_mem_responder.sv
// tb_shared_mem_responder: directed scenarios for arbitration, byte lanes, address wrap and reset.
module tb_shared_mem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req_valid = '0, req_we = '0;
  logic [127:0] req_addr = '0, req_wdata = '0;
  logic [15:0] req_be = '0;
  logic [3:0] req_ready, rsp_valid;
  logic [127:0] rsp_rdata;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  shared_mem_responder dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
  );

  task set_req(input int c, input logic we, input logic [31:0] a, input logic [31:0] d,
               input logic [3:0] be);
    req_valid[c] = 1'b1;
    req_we[c] = we;
    req_addr[32*c +: 32] = a;
    req_wdata[32*c +: 32] = d;
    req_be[4*c +: 4] = be;
  endtask

  task do_reset;
    req_valid = '0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task test_reset;
    for (int c = 0; c < 4; c++) set_req(c, 1'b0, 32'(c * 4), 32'h0, 4'hF);
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready got %h exp 0", req_ready); end
    checks++;
    if (rsp_valid !== 4'b0) begin errors++; $display("FAIL reset_rsp_valid got %h exp 0", rsp_valid); end
    checks++;
    if (rsp_rdata !== 128'b0) begin errors++; $display("FAIL reset_rsp_rdata got %h exp 0", rsp_rdata); end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task test_write_read;
    do_reset();
    set_req(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL wr_ready got %h exp 2", req_ready); end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL wr_rsp got %h exp 2", rsp_valid); end
    set_req(1, 1'b0, 32'h10, 32'h0, 4'h0);
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL rd_ready got %h exp 2", req_ready); end
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL rd_rsp got %h exp 2", rsp_valid); end
    checks++;
    if (rsp_rdata[63:32] !== 32'hDEADBEEF)
      begin errors++; $display("FAIL rd_data got %h exp deadbeef", rsp_rdata[63:32]); end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0) begin errors++; $display("FAIL rsp_single_pulse got %h exp 0", rsp_valid); end
  endtask

  task test_round_robin;
    logic [3:0] exp;
    do_reset();
    for (int c = 0; c < 4; c++) set_req(c, 1'b0, 32'h100 + 32'(c * 4), 32'h0, 4'h0);
    for (int k = 0; k < 8; k++) begin
      #1;
      exp = 4'b0001 << (k % 4);
      checks++;
      if (req_ready !== exp) begin errors++; $display("FAIL rr_ready[%0d] got %h exp %h", k, req_ready, exp); end
      if (k > 0) begin
        exp = 4'b0001 << ((k - 1) % 4);
        checks++;
        if (rsp_valid !== exp) begin errors++; $display("FAIL rr_rsp[%0d] got %h exp %h", k, rsp_valid, exp); end
      end
      @(negedge clk);
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  task test_byte_enable;
    set_req(0, 1'b1, 32'h20, 32'h11223344, 4'hF);
    @(negedge clk);
    req_valid = '0;
    set_req(2, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5);
    @(negedge clk);
    req_valid = '0;
    set_req(2, 1'b0, 32'h20, 32'h0, 4'h0);
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL be_rsp got %h exp 4", rsp_valid); end
    checks++;
    if (rsp_rdata[95:64] !== 32'h11BB33DD)
      begin errors++; $display("FAIL be_data got %h exp 11bb33dd", rsp_rdata[95:64]); end
    @(negedge clk);
  endtask

  task test_wrap;
    set_req(0, 1'b1, 32'h1004, 32'h5A5A5A5A, 4'hF);
    @(negedge clk);
    req_valid = '0;
    set_req(0, 1'b0, 32'h0004, 32'h0, 4'h0);
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (rsp_rdata[31:0] !== 32'h5A5A5A5A)
      begin errors++; $display("FAIL wrap_data got %h exp 5a5a5a5a", rsp_rdata[31:0]); end
    @(negedge clk);
  endtask

  task test_reset_pending;
    do_reset();
    set_req(2, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    checks++;
    if (rsp_valid !== 4'b0) begin errors++; $display("FAIL pend_in_reset got %h exp 0", rsp_valid); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(3, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    checks++;
    if (rsp_valid !== 4'b0) begin errors++; $display("FAIL pend_after_release got %h exp 0", rsp_valid); end
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL pend_first_grant got %h exp 1", req_ready); end
    @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin errors++; $display("FAIL pend_second_grant got %h exp 8", req_ready); end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
  endtask

  task test_back_to_back;
    set_req(3, 1'b0, 32'h40, 32'h0, 4'h0);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (req_ready !== 4'b1000) begin errors++; $display("FAIL b2b_ready[%0d] got %h exp 8", k, req_ready); end
      @(negedge clk);
      if (k == 2) req_valid = '0;
      checks++;
      if (rsp_valid !== 4'b1000) begin errors++; $display("FAIL b2b_rsp[%0d] got %h exp 8", k, rsp_valid); end
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0) begin errors++; $display("FAIL b2b_idle got %h exp 0", rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_byte_enable();
    test_wrap();
    test_reset_pending();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
